mul_div_sequencer: RTL and testbench
====================================

// Module: mul_div_sequencer
// PURPOSE
//  Multi-cycle MULT/MULTU/DIV/DIVU unit that writes the HI/LO register pair.
//  Sequences an iterative add/sub-shift datapath, one bit per cycle, with a
//  start/busy/done handshake toward the main control unit.
//  Sits beside ALU32Bit. The controller stalls the pipeline while o_busy=1
//  and reads o_hi/o_lo for MFHI/MFLO.
// PARAMETERS
//  WIDTH  32  operand width; o_hi/o_lo are WIDTH bits each
// PORTS
//  i_clk           in   1      clock, rising edge
//  i_rst_n         in   1      reset, asynchronous, active-low
//  i_start         in   1      request; sampled only in IDLE or DONE
//  i_op            in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  i_A             in   WIDTH  multiplicand / dividend
//  i_B             in   WIDTH  multiplier / divisor
//  o_busy          out  1      operation in progress (PREP/RUN/FIX)
//  o_done          out  1      one-cycle pulse; o_hi/o_lo valid from this cycle
//  o_hi            out  WIDTH  MUL: product[2W-1:W]; DIV: remainder
//  o_lo            out  WIDTH  MUL: product[W-1:0];  DIV: quotient
//  o_div_by_zero   out  1      set with o_done when a DIV/DIVU has B==0
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE.
//   o_busy=0, o_done=0, o_div_by_zero=0, o_hi=0, o_lo=0.
//   Reset mid-operation aborts the operation; no done pulse is produced.
//  FSM: IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
//  IDLE: when i_start=1, latch i_op/i_A/i_B and go to PREP.
//  PREP (1 cycle):
//   - Signed ops take magnitudes of A and B; record signA and signA^signB.
//   - Clear the 2W-bit accumulator and set counter=WIDTH-1.
//   - DIV/DIVU with B==0: go to DONE and skip RUN.
//  RUN (WIDTH cycles), one bit per cycle:
//   - MUL: if multiplier LSB=1, add the multiplicand into the upper half;
//     then shift right 1.
//   - DIV (restoring): shift the remainder:quotient left 1; trial-subtract
//     the divisor; if the result is non-negative, keep it and set the quotient
//     LSB, else restore.
//   - Exit to FIX when counter==0.
//  FIX (1 cycle):
//   - MULT: negate the 2W-bit product if signs differ.
//   - DIV: negate the quotient if signs differ; the remainder takes the sign
//     of A.
//   - Register the results into o_hi/o_lo at the FIX->DONE edge.
//  DONE (1 cycle): o_done=1, then IDLE.
//   - i_start=1 in DONE is accepted exactly as in IDLE (goes to PREP).
//   - This gives back-to-back operation.
//  Latency: start sampled at edge 0.
//   - o_busy=1 in cycles 1..WIDTH+2.
//   - o_done=1 in cycle WIDTH+3 (35 for WIDTH=32).
//   - Divide-by-zero: o_done=1 in cycle 2, with o_busy=1 in cycle 1 only.
//  Divide-by-zero result: o_hi=A, o_lo=all-ones, o_div_by_zero=1.
//   - o_div_by_zero holds until the next accepted start, then clears.
//  Overflow: DIV of 0x80000000 by -1 gives lo=0x80000000, hi=0 (magnitude
//  wrap). No flag is raised.
//  i_start while o_busy=1 is ignored. Operands and op are not re-sampled.
//  o_hi/o_lo change only at the edge that raises o_done; otherwise they hold
//  their last value. All arithmetic is modulo 2^WIDTH per half.
// TESTING
//  1 MULTU FFFFFFFF*FFFFFFFF -> o_done at cycle 35, hi=FFFFFFFE, lo=00000001.
//  2 MULT -3*5 -> hi=FFFFFFFF, lo=FFFFFFF1.
//    DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//    DIVU 100/7 -> lo=0000000E, hi=00000002.
//  3 DIVU 0x1234/0 -> o_done at cycle 2, o_div_by_zero=1, hi=00001234,
//    lo=FFFFFFFF; a following MULTU clears the flag at its start.
//  4 DIV 80000000/FFFFFFFF -> lo=80000000, hi=00000000, o_div_by_zero=0.
//  5 Pulse i_start with different operands at cycle 5 of a busy op -> ignored;
//    results match the first op only.
//    i_start held high in DONE -> new op, o_done again 35 cycles later.
//  6 Drop i_rst_n at cycle 10 of a MULT -> o_busy=0 and hi=lo=0 immediately;
//    no o_done pulse. After release, DIV 9/3 -> lo=3, hi=0.

Source files
------------

// File: rtl/mul_div_sequencer_if.sv
// Control-unit <-> multiply/divide sequencer connection.
//
// Handshake: the master raises i_start with i_op/i_A/i_B stable; the unit
// samples them only on an edge where it is in IDLE or DONE (o_busy=0).
// o_busy is high from the cycle after acceptance until results are ready;
// o_done pulses for exactly one cycle and o_hi/o_lo are valid from that
// cycle on, holding until the next completion. i_start while o_busy=1 is
// ignored.
interface mul_div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_A;
  logic [WIDTH-1:0] i_B;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  logic             o_div_by_zero;
  logic [2:0]       o_state;   // debug view of the sequencer FSM

  modport master (
    output i_start, i_op, i_A, i_B,
    input  o_busy, o_done, o_hi, o_lo, o_div_by_zero, o_state
  );

  modport slave (
    input  i_start, i_op, i_A, i_B,
    output o_busy, o_done, o_hi, o_lo, o_div_by_zero, o_state
  );
endinterface

// File: rtl/mul_div_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing the HI/LO register pair.
// One bit per cycle: shift-add multiply, restoring divide. Signed ops work
// on magnitudes and fix the signs in a single cycle at the end.
module mul_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  mul_div_sequencer_if.slave  bus
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q;
  logic [1:0]       op_q;        // bit1: divide, bit0: signed
  logic [WIDTH-1:0] a_q;         // raw A until PREP, then |A|
  logic [WIDTH-1:0] b_q;         // raw B until PREP, then |B|
  logic             sign_a_q;
  logic             sign_diff_q;
  logic [W2-1:0]    acc_q;       // MUL: {partial, multiplier}; DIV: {rem, quo}
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             is_div;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_ext;
  logic [WIDTH+1:0] trial;
  logic [W2-1:0]    acc_mul_d;
  logic [W2-1:0]    acc_div_d;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] fix_hi_d;
  logic [WIDTH-1:0] fix_lo_d;

  // Datapath: operand magnitudes, one multiply/divide step, final sign fix
  always_comb begin
    is_div    = op_q[1];
    is_signed = op_q[0];
    a_neg     = is_signed & a_q[WIDTH-1];
    b_neg     = is_signed & b_q[WIDTH-1];
    a_mag     = a_neg ? (WIDTH'(0) - a_q) : a_q;
    b_mag     = b_neg ? (WIDTH'(0) - b_q) : b_q;

    // Multiply step: conditional add into upper half, then shift right.
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, a_q};
    acc_mul_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                         : {1'b0, acc_q[W2-1:1]};

    // Divide step: shifted remainder needs one extra bit before the
    // trial subtract because 2*rem+1 can exceed WIDTH bits.
    rem_ext   = acc_q[W2-1:WIDTH-1];
    trial     = {1'b0, rem_ext} - {2'b00, b_q};
    acc_div_d = trial[WIDTH+1] ? {acc_q[W2-2:0], 1'b0}
                               : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Sign correction applied in FIX.
    prod_fix  = (is_signed & sign_diff_q) ? (W2'(0) - acc_q) : acc_q;
    if (is_div) begin
      fix_lo_d = (is_signed & sign_diff_q) ? (WIDTH'(0) - acc_q[WIDTH-1:0])
                                           : acc_q[WIDTH-1:0];
      fix_hi_d = (is_signed & sign_a_q) ? (WIDTH'(0) - acc_q[W2-1:WIDTH])
                                        : acc_q[W2-1:WIDTH];
    end else begin
      fix_lo_d = prod_fix[WIDTH-1:0];
      fix_hi_d = prod_fix[W2-1:WIDTH];
    end
  end

  // Sequencer FSM with registered handshake outputs and result registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sign_a_q    <= 1'b0;
      sign_diff_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            op_q    <= bus.i_op;
            a_q     <= bus.i_A;
            b_q     <= bus.i_B;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_PREP: begin
          if (is_div && (b_q == '0)) begin
            hi_q    <= a_q;
            lo_q    <= '1;
            dbz_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            sign_a_q    <= a_neg;
            sign_diff_q <= a_neg ^ b_neg;
            a_q         <= a_mag;
            b_q         <= b_mag;
            acc_q       <= is_div ? {WIDTH'(0), a_mag} : {WIDTH'(0), b_mag};
            cnt_q       <= CW'(WIDTH - 1);
            state_q     <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= is_div ? acc_div_d : acc_mul_d;
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_hi          = hi_q;
  assign bus.o_lo          = lo_q;
  assign bus.o_div_by_zero = dbz_q;
  assign bus.o_state       = state_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer (WIDTH=32).
module tb_mul_div_sequencer;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mul_div_sequencer_if #(.WIDTH(32)) bus ();

  mul_div_sequencer #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive a request; caller is at a negedge. Returns right after the
  // sampling edge (edge 0).
  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_A     = a;
    bus.i_B     = b;
    @(posedge clk);
  endtask

  // Follow an accepted op to its done pulse and check everything about it.
  // Optionally pulses i_start with other operands at cycle pulse_at.
  // Returns at the negedge inside the DONE cycle with i_start low.
  task automatic wait_result(input string name, input int exp_cyc,
                             input int exp_busy, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input logic exp_dbz,
                             input int pulse_at);
    int          cyc;
    int          busy_cnt;
    logic        seen;
    logic        moved;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    @(negedge clk);
    bus.i_start = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    seen     = 1'b0;
    moved    = 1'b0;
    hold_hi  = bus.o_hi;
    hold_lo  = bus.o_lo;
    checks++;
    if (bus.o_div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL %s dbz_clear_at_start: got %b want 0", name, bus.o_div_by_zero);
    end
    checks++;
    if (bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_cycle1: got %b want 1", name, bus.o_busy);
    end
    while (cyc < 200) begin
      if (bus.o_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.o_busy === 1'b1) busy_cnt++;
      if (bus.o_hi !== hold_hi || bus.o_lo !== hold_lo) moved = 1'b1;
      if (pulse_at != 0 && cyc == pulse_at) begin
        bus.i_start = 1'b1;
        bus.i_op    = OP_DIVU;
        bus.i_A     = 32'h0000_DEAD;
        bus.i_B     = 32'h0000_0003;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: no o_done within %0d cycles", name, cyc);
    end
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (busy_cnt != exp_busy) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_busy);
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL %s hilo_hold: results changed before o_done (hi %h lo %h)",
               name, bus.o_hi, bus.o_lo);
    end
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_done: got %b want 0", name, bus.o_busy);
    end
    checks++;
    if (bus.o_hi !== exp_hi) begin
      errors++;
      $display("FAIL %s hi: got %h want %h", name, bus.o_hi, exp_hi);
    end
    checks++;
    if (bus.o_lo !== exp_lo) begin
      errors++;
      $display("FAIL %s lo: got %h want %h", name, bus.o_lo, exp_lo);
    end
    checks++;
    if (bus.o_div_by_zero !== exp_dbz) begin
      errors++;
      $display("FAIL %s dbz: got %b want %b", name, bus.o_div_by_zero, exp_dbz);
    end
    bus.i_start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_cyc, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dbz);
    @(negedge clk);
    issue(op, a, b);
    wait_result(name, exp_cyc, exp_busy, exp_hi, exp_lo, exp_dbz, 0);
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_op    = 2'b00;
    bus.i_A     = '0;
    bus.i_B     = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy %b done %b dbz %b want 0 0 0",
               bus.o_busy, bus.o_done, bus.o_div_by_zero);
    end
    checks++;
    if (bus.o_hi !== 32'h0 || bus.o_lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo: hi %h lo %h want 0 0", bus.o_hi, bus.o_lo);
    end
    checks++;
    if (bus.o_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", bus.o_state);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_multu();
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 34,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.o_done !== 1'b0 || bus.o_state !== 3'd0) begin
      errors++;
      $display("FAIL done_one_cycle: done %b state %0d want 0 0", bus.o_done, bus.o_state);
    end
    checks++;
    if (bus.o_hi !== 32'hFFFF_FFFE || bus.o_lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL hilo_after_done: hi %h lo %h want fffffffe 00000001", bus.o_hi, bus.o_lo);
    end
    run_op("multu_shift", OP_MULTU, 32'h1234_5678, 32'h0000_0010, 35, 34,
           32'h0000_0001, 32'h2345_6780, 1'b0);
  endtask

  task automatic test_mult();
    run_op("mult_neg_pos", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 35, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("mult_neg_neg", OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFA, 35, 34,
           32'h0000_0000, 32'h0000_0018, 1'b0);
  endtask

  task automatic test_div();
    run_op("div_neg_pos", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 35, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 35, 34,
           32'h0000_0002, 32'h0000_000E, 1'b0);
    run_op("div_pos_neg", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 35, 34,
           32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0001, 35, 34,
           32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_div_by_zero();
    run_op("divu_by_zero", OP_DIVU, 32'h0000_1234, 32'h0, 2, 1,
           32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.o_div_by_zero !== 1'b1 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL dbz_hold: dbz %b done %b want 1 0", bus.o_div_by_zero, bus.o_done);
    end
    run_op("multu_after_dbz", OP_MULTU, 32'h3, 32'h4, 35, 34,
           32'h0000_0000, 32'h0000_000C, 1'b0);
  endtask

  task automatic test_overflow();
    run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 35, 34,
           32'h0000_0000, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_ignored_start();
    @(negedge clk);
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_result("ignored_start", 35, 34, 32'h0000_0000, 32'h0000_002A, 1'b0, 5);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 35, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    // Still inside the DONE cycle: this request must be accepted.
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_result("b2b_second", 35, 34, 32'h0000_0002, 32'h0000_000E, 1'b0, 0);
  endtask

  task automatic test_reset_abort();
    logic done_seen;
    @(negedge clk);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before: got %b want 1", bus.o_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_state !== 3'd0) begin
      errors++;
      $display("FAIL abort_flags: busy %b done %b state %0d want 0 0 0",
               bus.o_busy, bus.o_done, bus.o_state);
    end
    checks++;
    if (bus.o_hi !== 32'h0 || bus.o_lo !== 32'h0) begin
      errors++;
      $display("FAIL abort_hilo: hi %h lo %h want 0 0", bus.o_hi, bus.o_lo);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin
      errors++;
      $display("FAIL abort_no_done: got a done pulse want none");
    end
    run_op("div_9_3", OP_DIV, 32'd9, 32'd3, 35, 34,
           32'h0000_0000, 32'h0000_0003, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_by_zero();
    test_overflow();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
